fifo_rd_ctrl: RTL and testbench

Read-side (consumer-domain) controller for the asynchronous FIFO; the counterpart of the producer-side write controller.
- Synchronizes the write pointer and decodes it from Gray to binary.
- Derives EMPTY, ALMOST_EMPTY and fill level; arbitrates reads.
- Drives the memory read address and returns read data with a valid strobe.
- Runs entirely on the consumer clock (225 MHz in the bench) and publishes its Gray read pointer back to the write domain.

---
 rtl/ccd_pkg.sv | 23 ++
 rtl/fifo_rd_ctrl_if.sv | 30 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/fifo_rd_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ccd_pkg.sv
`timescale 1ns/1ps
// Shared clock-domain-crossing FIFO types and Gray/binary helpers for the write and read controllers.
package ccd_pkg;

  localparam int CCD_ADDR_W = 8;
  localparam int CCD_DATA_W = 8;

  typedef logic [CCD_ADDR_W:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[CCD_ADDR_W] = g[CCD_ADDR_W];
    for (int i = CCD_ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
`timescale 1ns/1ps
// Read-side FIFO bus: consumer request, write pointer in, memory read port and status flags out.
interface fifo_rd_ctrl_if
  import ccd_pkg::*;
#(
  parameter int ADDR_W = CCD_ADDR_W,
  parameter int DATA_W = CCD_DATA_W
);
  logic              RD_EN;
  logic [ADDR_W:0]   WPTR_GRAY;
  logic [DATA_W-1:0] MEM_RDATA;
  logic [ADDR_W-1:0] RADDR;
  logic [ADDR_W:0]   RPTR_GRAY;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              EMPTY;
  logic              ALMOST_EMPTY;
  logic [ADDR_W:0]   RD_LEVEL;
  logic              UNDERFLOW;

  modport master (
    output RD_EN, WPTR_GRAY, MEM_RDATA,
    input  RADDR, RPTR_GRAY, RDATA, RVALID, EMPTY, ALMOST_EMPTY, RD_LEVEL, UNDERFLOW
  );

  modport slave (
    input  RD_EN, WPTR_GRAY, MEM_RDATA,
    output RADDR, RPTR_GRAY, RDATA, RVALID, EMPTY, ALMOST_EMPTY, RD_LEVEL, UNDERFLOW
  );
endinterface

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchronizer for Gray pointers crossing into clk; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
`timescale 1ns/1ps
// Async FIFO read controller; 1-cycle read data, empty deasserts 3 edges after a write. Reads while empty are dropped.
// Define FIFO_RD_UNDERFLOW_CHK_EN for the sticky UNDERFLOW flag and the level-range assertion.
module fifo_rd_ctrl
  import ccd_pkg::*;
#(
  parameter int ADDR_W    = CCD_ADDR_W,
  parameter int DATA_W    = CCD_DATA_W,
  parameter int AE_THRESH = 4
) (
  input logic           CLK,
  input logic           RST,
  fifo_rd_ctrl_if.slave bus
);
  typedef logic [ADDR_W:0] lptr_t;

  localparam lptr_t AE_LVL  = lptr_t'(AE_THRESH);
  localparam lptr_t MAX_LVL = lptr_t'(1) << ADDR_W;

  lptr_t             wg_s, wb;
  logic              acc;
  lptr_t             rbin_d, rbin_q;
  lptr_t             rptr_gray_d, rptr_gray_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rvalid_d, rvalid_q;
  logic              empty_d, empty_q;
  logic              ae_d, ae_q;
  lptr_t             level_d, level_q;

  sync_2ff #(.W(ADDR_W + 1)) u_wptr_sync (
    .clk (CLK),
    .rst (RST),
    .d   (bus.WPTR_GRAY),
    .q   (wg_s)
  );

  assign wb = gray2bin(wg_s);

  // Flags are computed from the post-read pointer so empty asserts on the accept edge itself.
  always_comb begin
    acc         = bus.RD_EN & ~empty_q;
    rbin_d      = rbin_q;
    rptr_gray_d = rptr_gray_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    if (acc) begin
      rbin_d      = rbin_q + lptr_t'(1);
      rptr_gray_d = bin2gray(rbin_d);
      rdata_d     = bus.MEM_RDATA;
      rvalid_d    = 1'b1;
    end
    level_d = wb - rbin_d;
    empty_d = (bin2gray(rbin_d) == wg_s);
    ae_d    = (level_d <= AE_LVL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      level_q     <= '0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      empty_q     <= empty_d;
      ae_q        <= ae_d;
      level_q     <= level_d;
    end
  end

  assign bus.RADDR        = rbin_q[ADDR_W-1:0];
  assign bus.RPTR_GRAY    = rptr_gray_q;
  assign bus.RDATA        = rdata_q;
  assign bus.RVALID       = rvalid_q;
  assign bus.EMPTY        = empty_q;
  assign bus.ALMOST_EMPTY = ae_q;
  assign bus.RD_LEVEL     = level_q;

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
  logic underflow_d, underflow_q;

  always_comb begin
    underflow_d = underflow_q | (bus.RD_EN & empty_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) underflow_q <= 1'b0;
    else     underflow_q <= underflow_d;
  end

  assign bus.UNDERFLOW = underflow_q;

  // A level beyond the FIFO depth can only come from a misbehaving writer.
  level_in_range_a: assert property (@(posedge CLK) disable iff (RST) level_q <= MAX_LVL);
`else
  assign bus.UNDERFLOW = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
`timescale 1ns/1ps
// Directed bench for fifo_rd_ctrl with a read-data scoreboard and a combinational memory model.
module tb_fifo_rd_ctrl;
  import ccd_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
  localparam bit UF_ON = 1'b1;
`else
  localparam bit UF_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;

  fifo_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AE_THRESH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #2.222 CLK = ~CLK;

  logic [7:0] mem [256];
  assign bus.MEM_RDATA = mem[bus.RADDR];

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] sb_q [$];
  logic [8:0] rb_tb;
  bit         exp_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    chk("rvalid", {31'd0, bus.RVALID}, {31'd0, exp_v});
    if (exp_v) chk("rdata", {24'd0, bus.RDATA}, {24'd0, sb_q.pop_front()});
    exp_v = 1'b0;
  endtask

  task automatic set_wptr(input logic [8:0] b);
    bus.WPTR_GRAY = b ^ (b >> 1);
  endtask

  task automatic rd(input bit accept);
    bus.RD_EN = 1'b1;
    if (accept) begin
      sb_q.push_back(mem[rb_tb[7:0]]);
      rb_tb = rb_tb + 9'd1;
      exp_v = 1'b1;
    end
    step();
  endtask

  task automatic do_reset();
    RST           = 1'b1;
    bus.WPTR_GRAY = '0;
    rb_tb         = '0;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hA5 ^ 8'(i);
    exp_v         = 1'b0;
    rb_tb         = '0;
    RST           = 1'b1;
    bus.RD_EN     = 1'b1;
    bus.WPTR_GRAY = '0;

    // 1. reset with RD_EN held high
    step();
    step();
    chk("rst_empty", {31'd0, bus.EMPTY}, 32'd1);
    chk("rst_ae",    {31'd0, bus.ALMOST_EMPTY}, 32'd1);
    chk("rst_level", {23'd0, bus.RD_LEVEL}, 32'd0);
    chk("rst_rptr",  {23'd0, bus.RPTR_GRAY}, 32'd0);
    chk("rst_rdata", {24'd0, bus.RDATA}, 32'd0);
    chk("rst_raddr", {24'd0, bus.RADDR}, 32'd0);
    chk("rst_uf",    {31'd0, bus.UNDERFLOW}, 32'd0);
    RST       = 1'b0;
    bus.RD_EN = 1'b0;

    // 2. single write, 3-edge empty deassert, single read
    bus.WPTR_GRAY = 9'b000000001;
    step();
    chk("t2_empty_e1", {31'd0, bus.EMPTY}, 32'd1);
    step();
    chk("t2_empty_e2", {31'd0, bus.EMPTY}, 32'd1);
    step();
    chk("t2_empty_e3", {31'd0, bus.EMPTY}, 32'd0);
    chk("t2_level",    {23'd0, bus.RD_LEVEL}, 32'd1);
    chk("t2_ae",       {31'd0, bus.ALMOST_EMPTY}, 32'd1);
    rd(1'b1);
    bus.RD_EN = 1'b0;
    chk("t2_rdata_a5", {24'd0, bus.RDATA}, 32'hA5);
    chk("t2_empty_rd", {31'd0, bus.EMPTY}, 32'd1);
    chk("t2_rptr",     {23'd0, bus.RPTR_GRAY}, 32'h001);
    chk("t2_level_rd", {23'd0, bus.RD_LEVEL}, 32'd0);

    // 3. mid-operation reset, then full level drained back-to-back
    do_reset();
    chk("t3_rst_empty", {31'd0, bus.EMPTY}, 32'd1);
    chk("t3_rst_rptr",  {23'd0, bus.RPTR_GRAY}, 32'd0);
    bus.WPTR_GRAY = 9'b110000000;
    step();
    step();
    step();
    chk("t3_level_full", {23'd0, bus.RD_LEVEL}, 32'd256);
    chk("t3_ae_full",    {31'd0, bus.ALMOST_EMPTY}, 32'd0);
    chk("t3_empty_full", {31'd0, bus.EMPTY}, 32'd0);
    for (int k = 1; k <= 256; k++) begin
      rd(1'b1);
      chk("t3_level", {23'd0, bus.RD_LEVEL}, 32'(256 - k));
      chk("t3_raddr", {24'd0, bus.RADDR}, {24'd0, rb_tb[7:0]});
      if (k == 251) chk("t3_ae_lvl5",    {31'd0, bus.ALMOST_EMPTY}, 32'd0);
      if (k == 252) chk("t3_ae_lvl4",    {31'd0, bus.ALMOST_EMPTY}, 32'd1);
      if (k == 255) chk("t3_empty_255",  {31'd0, bus.EMPTY}, 32'd0);
      if (k == 256) chk("t3_empty_256",  {31'd0, bus.EMPTY}, 32'd1);
    end
    // read while empty: dropped, data holds
    rd(1'b0);
    bus.RD_EN = 1'b0;
    chk("t3_rdata_hold", {24'd0, bus.RDATA}, 32'h5A);
    chk("t3_raddr_hold", {24'd0, bus.RADDR}, 32'd0);
    chk("t3_uf",         {31'd0, bus.UNDERFLOW}, {31'd0, UF_ON});

    // 4. wrap-around of the read pointer 511 -> 0
    set_wptr(9'd511);
    step();
    step();
    step();
    chk("t4_level_255", {23'd0, bus.RD_LEVEL}, 32'd255);
    for (int k = 0; k < 255; k++) rd(1'b1);
    bus.RD_EN = 1'b0;
    chk("t4_rptr_511",  {23'd0, bus.RPTR_GRAY}, 32'h100);
    chk("t4_raddr_255", {24'd0, bus.RADDR}, 32'd255);
    chk("t4_empty_511", {31'd0, bus.EMPTY}, 32'd1);
    set_wptr(9'd0);
    step();
    step();
    step();
    chk("t4_level_wrap", {23'd0, bus.RD_LEVEL}, 32'd1);
    chk("t4_empty_wrap", {31'd0, bus.EMPTY}, 32'd0);
    rd(1'b1);
    bus.RD_EN = 1'b0;
    chk("t4_rptr_0",  {23'd0, bus.RPTR_GRAY}, 32'd0);
    chk("t4_raddr_0", {24'd0, bus.RADDR}, 32'd0);
    chk("t4_empty_0", {31'd0, bus.EMPTY}, 32'd1);

    // 5. write-pointer increment and read land on the same edge
    set_wptr(9'd2);
    step();
    step();
    step();
    chk("t5_level_pre", {23'd0, bus.RD_LEVEL}, 32'd2);
    set_wptr(9'd3);
    step();
    step();
    chk("t5_level_sync", {23'd0, bus.RD_LEVEL}, 32'd2);
    rd(1'b1);
    bus.RD_EN = 1'b0;
    chk("t5_level_both", {23'd0, bus.RD_LEVEL}, 32'd2);
    chk("t5_empty",      {31'd0, bus.EMPTY}, 32'd0);
    step();
    chk("t5_level_after", {23'd0, bus.RD_LEVEL}, 32'd2);

    // 6. underflow stickiness
    rd(1'b1);
    rd(1'b1);
    bus.RD_EN = 1'b0;
    chk("t6_empty", {31'd0, bus.EMPTY}, 32'd1);
    rd(1'b0);
    bus.RD_EN = 1'b0;
    chk("t6_uf_set", {31'd0, bus.UNDERFLOW}, {31'd0, UF_ON});
    set_wptr(9'd4);
    step();
    step();
    step();
    chk("t6_empty_wr", {31'd0, bus.EMPTY}, 32'd0);
    rd(1'b1);
    bus.RD_EN = 1'b0;
    chk("t6_uf_hold", {31'd0, bus.UNDERFLOW}, {31'd0, UF_ON});
    do_reset();
    chk("t6_uf_clr", {31'd0, bus.UNDERFLOW}, 32'd0);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
